// File: rtl/mdio_master.sv
// Clause-22/45 MDIO master: optional preamble, 32-bit frame shifted MSB-first, 16-bit capture on read opcodes.
// MDC is low for CLK_DIV clocks then high for CLK_DIV clocks per bit; mdio_start is ignored while busy.
module mdio_master #(
   parameter int CLK_DIV      = 4,
   parameter int PREAMBLE_LEN = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mdio_start,
   input  logic [31:0] t_data,
   input  logic        mdio_in,
   output logic [15:0] rd_data,
   output logic        data_rdy,
   output logic        mdc,
   output logic        mdio_oe,
   output logic        mdio_out,
   output logic        busy
);

   localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
   localparam logic [5:0] PRE_LAST = (PREAMBLE_LEN > 0) ? 6'(PREAMBLE_LEN - 1) : 6'd0;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PRE  = 3'd1;
   localparam logic [2:0] S_HDR  = 3'd2;
   localparam logic [2:0] S_TA   = 3'd3;
   localparam logic [2:0] S_DATA = 3'd4;

   logic [2:0]      state_q, state_d;
   logic [DIVW-1:0] div_q, div_d;
   logic            mdc_q, mdc_d;
   logic [5:0]      bit_q, bit_d;
   logic [5:0]      bit_last;
   logic [31:0]     shift_q, shift_d;
   logic            rd_op_q, rd_op_d;
   logic [15:0]     cap_q, cap_d;
   logic [15:0]     rd_data_q, rd_data_d;
   logic            data_rdy_q, data_rdy_d;
   logic            busy_q, busy_d;
   logic            oe_q, out_q;
   logic [1:0]      drv_d;

   // Pad drive for a bit as {oe, out}; read frames release the line from turnaround on.
   function automatic logic [1:0] drive(input logic [2:0] st, input logic rd, input logic msb);
      logic [1:0] r;
      r = 2'b00;
      case (st)
         S_PRE:          r = 2'b11;
         S_HDR:          r = {1'b1, msb};
         S_TA, S_DATA:   r = rd ? 2'b00 : {1'b1, msb};
         default:        r = 2'b00;
      endcase
      return r;
   endfunction

   always_comb begin
      case (state_q)
         S_PRE:   bit_last = PRE_LAST;
         S_HDR:   bit_last = 6'd13;
         S_TA:    bit_last = 6'd1;
         default: bit_last = 6'd15;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      mdc_d      = mdc_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      rd_op_d    = rd_op_q;
      cap_d      = cap_q;
      rd_data_d  = rd_data_q;
      data_rdy_d = 1'b0;
      busy_d     = busy_q;
      if (!busy_q) begin
         if (mdio_start) begin
            state_d = (PREAMBLE_LEN > 0) ? S_PRE : S_HDR;
            shift_d = t_data;
            rd_op_d = t_data[29];
            busy_d  = 1'b1;
            div_d   = '0;
            mdc_d   = 1'b0;
            bit_d   = 6'd0;
         end
      end else if (div_q == DIV_LAST) begin
         div_d = '0;
         mdc_d = ~mdc_q;
         if (!mdc_q && state_q == S_DATA && rd_op_q)
            cap_d = {cap_q[14:0], mdio_in};
         // End of the high phase closes the current bit.
         if (mdc_q) begin
            if (state_q != S_PRE)
               shift_d = {shift_q[30:0], 1'b0};
            if (bit_q == bit_last) begin
               bit_d = 6'd0;
               case (state_q)
                  S_PRE:   state_d = S_HDR;
                  S_HDR:   state_d = S_TA;
                  S_TA:    state_d = S_DATA;
                  default: begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                     if (rd_op_q) begin
                        rd_data_d  = cap_q;
                        data_rdy_d = 1'b1;
                     end
                  end
               endcase
            end else begin
               bit_d = bit_q + 6'd1;
            end
         end
      end else begin
         div_d = div_q + 1'b1;
      end
      drv_d = drive(state_d, rd_op_d, shift_d[31]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         mdc_q      <= 1'b0;
         bit_q      <= 6'd0;
         shift_q    <= 32'd0;
         rd_op_q    <= 1'b0;
         cap_q      <= 16'd0;
         rd_data_q  <= 16'd0;
         data_rdy_q <= 1'b0;
         busy_q     <= 1'b0;
         oe_q       <= 1'b0;
         out_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         mdc_q      <= mdc_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         rd_op_q    <= rd_op_d;
         cap_q      <= cap_d;
         rd_data_q  <= rd_data_d;
         data_rdy_q <= data_rdy_d;
         busy_q     <= busy_d;
         oe_q       <= drv_d[1];
         out_q      <= drv_d[0];
      end
   end

   assign rd_data  = rd_data_q;
   assign data_rdy = data_rdy_q;
   assign mdc      = mdc_q;
   assign mdio_oe  = oe_q;
   assign mdio_out = out_q;
   assign busy     = busy_q;

endmodule
